// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C bus arbiter: state encoding, counter width
// and a saturating increment helper.
package i2c_arb_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } arb_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/i2c_arb_rr.sv
// Two-requester round-robin pick: a lone request wins outright, contention
// goes to whichever requester did not own the bus last.
module i2c_arb_rr (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       next_owner,
  output logic       valid
);

  always_comb begin
    valid      = |req;
    next_owner = 1'b0;
    if (req == 2'b11) begin
      next_owner = ~last_owner;
    end else if (req[1]) begin
      next_owner = 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bus_arb.sv
// I2C bus arbiter sharing one SCL/SDA pad pair between the ADV7513 init engine
// and the register reader. Define I2C_ARB_TIMEOUT_EN to build in the grant watchdog.
module i2c_bus_arb
  import i2c_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] GUARD_CYCLES   = 24'd600,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic [1:0] scl_oe_req,
  input  logic [1:0] sda_oe_req,
  output logic [1:0] gnt,
  output logic       owner,
  output logic       busy,
  output logic       timeout_err,
  output logic       scl_oe,
  output logic       sda_oe
);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             pick_owner;
  logic             pick_valid;
  logic             watchdog_hit;
  logic             grant_end;

  i2c_arb_rr u_rr (
    .req        (req),
    .last_owner (owner),
    .next_owner (pick_owner),
    .valid      (pick_valid)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  logic timeout_err_q;
  assign watchdog_hit = (cnt == TIMEOUT_CYCLES - 1'b1);
  assign timeout_err  = timeout_err_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
  assign watchdog_hit = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // Only the current owner's done/req can end a grant.
  assign grant_end = done[owner] || !req[owner] || watchdog_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 2'b00;
      owner <= 1'b1;
      busy  <= 1'b0;
      cnt   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef I2C_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= GRANT;
            busy  <= 1'b1;
            owner <= pick_owner;
            gnt   <= pick_owner ? 2'b10 : 2'b01;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (grant_end) begin
            state <= GUARD;
            gnt   <= 2'b00;
            cnt   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            timeout_err_q <= watchdog_hit && !done[owner];
`endif
          end else begin
`ifdef I2C_ARB_TIMEOUT_EN
            cnt <= sat_inc(cnt);
`endif
          end
        end
        GUARD: begin
          // Bus stays released for exactly GUARD_CYCLES cycles, then one IDLE cycle.
          if (cnt == GUARD_CYCLES - 1'b1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign scl_oe = (state == GRANT) && scl_oe_req[owner];
  assign sda_oe = (state == GRANT) && sda_oe_req[owner];

endmodule

// File: tb/tb_i2c_bus_arb.sv
// Directed self-checking bench for i2c_bus_arb; the watchdog scenarios follow
// whether I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_bus_arb;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] scl_oe_req;
  logic [1:0] sda_oe_req;
  logic [1:0] gnt;
  logic       owner;
  logic       busy;
  logic       timeout_err;
  logic       scl_oe;
  logic       sda_oe;

  int checks = 0;
  int errors = 0;
  int n;
  int err_seen;

  i2c_bus_arb #(
    .GUARD_CYCLES   (24'd600),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .scl_oe_req  (scl_oe_req),
    .sda_oe_req  (sda_oe_req),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] d,
                               input logic [1:0] scl, input logic [1:0] sda);
    req        = r;
    done       = d;
    scl_oe_req = scl;
    sda_oe_req = sda;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
    do_reset();

    // Reset state
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 1);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_scl", scl_oe, 0);
    checkOutput("rst_sda", sda_oe, 0);

    // Single request, done pulse, guard length
    applyStimulus(2'b01, 2'b00, 2'b01, 2'b00);
    #1;
    checkOutput("s1_gnt_before_edge", gnt, 0);
    tick();
    checkOutput("s1_gnt", gnt, 2'b01);
    checkOutput("s1_owner", owner, 0);
    checkOutput("s1_busy", busy, 1);
    checkOutput("s1_scl", scl_oe, 1);
    checkOutput("s1_sda", sda_oe, 0);
    applyStimulus(2'b01, 2'b01, 2'b01, 2'b00);
    tick();
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b00);
    checkOutput("s1_gnt_after_done", gnt, 0);
    checkOutput("s1_scl_guard", scl_oe, 0);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      tick();
    end
    checkOutput("s1_guard_len", n, 600);
    checkOutput("s1_idle_gnt", gnt, 0);

    // Simultaneous requests after reset: requester 0 first, then 1
    do_reset();
    applyStimulus(2'b11, 2'b00, 2'b00, 2'b00);
    tick();
    checkOutput("s2_first_gnt", gnt, 2'b01);
    applyStimulus(2'b10, 2'b01, 2'b00, 2'b00);
    tick();
    applyStimulus(2'b10, 2'b00, 2'b00, 2'b00);
    n = 1;
    while (gnt == 2'b00 && n < 2000) begin
      tick();
      if (gnt == 2'b00) n++;
    end
    checkOutput("s2_gap", n, 601);
    checkOutput("s2_second_gnt", gnt, 2'b10);
    checkOutput("s2_owner", owner, 1);

    // Pad muxing follows owner 1 only; non-owner events ignored
    applyStimulus(2'b10, 2'b00, 2'b01, 2'b01);
    #1;
    checkOutput("s3_scl_nonowner", scl_oe, 0);
    checkOutput("s3_sda_nonowner", sda_oe, 0);
    applyStimulus(2'b10, 2'b00, 2'b10, 2'b00);
    #1;
    checkOutput("s3_scl_owner", scl_oe, 1);
    checkOutput("s3_sda_owner", sda_oe, 0);
    applyStimulus(2'b11, 2'b01, 2'b10, 2'b00);
    tick();
    applyStimulus(2'b11, 2'b00, 2'b10, 2'b00);
    tick();
    checkOutput("s3_nonowner_done_gnt", gnt, 2'b10);
    checkOutput("s3_nonowner_busy", busy, 1);
    applyStimulus(2'b11, 2'b10, 2'b10, 2'b10);
    tick();
    applyStimulus(2'b11, 2'b00, 2'b10, 2'b10);
    checkOutput("s3_gnt_after_done", gnt, 0);
    checkOutput("s3_scl_guard", scl_oe, 0);
    checkOutput("s3_sda_guard", sda_oe, 0);
    n = 0;
    while (gnt == 2'b00 && n < 2000) begin
      n++;
      tick();
    end
    checkOutput("s3_rr_gnt", gnt, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    checkOutput("s3_req_drop_gnt", gnt, 0);
    checkOutput("s3_req_drop_busy", busy, 1);

    // Watchdog
    do_reset();
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
    tick();
    checkOutput("s4_gnt", gnt, 2'b01);
`ifdef I2C_ARB_TIMEOUT_EN
    n = 1;
    while (gnt != 2'b00 && n < 1500) begin
      tick();
      if (gnt != 2'b00) n++;
    end
    checkOutput("s4_grant_len", n, 100);
    checkOutput("s4_timeout_pulse", timeout_err, 1);
    tick();
    checkOutput("s4_timeout_one_cycle", timeout_err, 0);
    checkOutput("s4_gnt_after", gnt, 0);
`else
    err_seen = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (timeout_err !== 1'b0) err_seen++;
    end
    checkOutput("s4_gnt_held", gnt, 2'b01);
    checkOutput("s4_no_timeout", err_seen, 0);
`endif

    // Done on the watchdog's last cycle: done wins
    do_reset();
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
    tick();
    repeat (99) tick();
    checkOutput("s5_gnt_at_100", gnt, 2'b01);
    applyStimulus(2'b01, 2'b01, 2'b00, 2'b00);
    tick();
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
    checkOutput("s5_gnt", gnt, 0);
    checkOutput("s5_no_timeout", timeout_err, 0);

    // Reset during a grant
    do_reset();
    applyStimulus(2'b11, 2'b00, 2'b11, 2'b11);
    tick();
    repeat (49) tick();
    checkOutput("s6_scl_before", scl_oe, 1);
    reset = 1'b1;
    tick();
    checkOutput("s6_gnt", gnt, 0);
    checkOutput("s6_scl", scl_oe, 0);
    checkOutput("s6_sda", sda_oe, 0);
    checkOutput("s6_timeout", timeout_err, 0);
    checkOutput("s6_busy", busy, 0);
    reset = 1'b0;
    tick();
    checkOutput("s6_first_gnt", gnt, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
